// File: rtl/tqvp_dlmiles_i2c_engine.sv
// tqvp_dlmiles_i2c_engine: single-master I2C bit/byte engine between the I2C FIFO and open-drain SCL/SDA.
module tqvp_dlmiles_i2c_engine #(
   parameter int CLK_DIV = 160
) (
   input  logic       clk,
   input  logic       rst_i,
   input  logic [8:0] i2c_txd_data_i,
   input  logic       i2c_txd_valid_i,
   output logic       i2c_txd_ready_o,
   output logic [7:0] i2c_rxd_data_o,
   output logic       i2c_rxd_valid_o,
   input  logic       auto_stop_i,
   input  logic       nack_clr_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_oe_o,
   output logic       sda_oe_o,
   output logic       st_busy_o,
   output logic       st_nack_o
);
   typedef enum logic [2:0] {IDLE, START, BIT, ACK, HOLD, STOP} state_t;
   localparam logic [9:0] RELOAD = 10'(CLK_DIV - 1);
   state_t     state;
   logic [9:0] tmr;
   logic [1:0] q;
   logic [2:0] bitc;
   logic [7:0] shift;
   logic       dir;
   logic       nak;
   logic       stall;
   logic       qend;
   logic       first;
   logic       new_sda;
   assign stall    = !scl_i && ((((state == BIT) || (state == ACK)) && (q == 2'd2)) || ((state == STOP) && (q == 2'd1)));
   assign qend     = (tmr == 10'd0) && !stall;
   assign first    = tmr == RELOAD;
   assign new_sda  = ~i2c_txd_data_i[8] & ~i2c_txd_data_i[7];
   assign st_busy_o = state != IDLE;
   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) begin
         state           <= IDLE;
         tmr             <= RELOAD;
         q               <= 2'd0;
         bitc            <= 3'd0;
         shift           <= 8'd0;
         dir             <= 1'b0;
         nak             <= 1'b0;
         scl_oe_o        <= 1'b0;
         sda_oe_o        <= 1'b0;
         i2c_txd_ready_o <= 1'b0;
         i2c_rxd_valid_o <= 1'b0;
         i2c_rxd_data_o  <= 8'd0;
         st_nack_o       <= 1'b0;
      end else begin
         i2c_txd_ready_o <= 1'b0;
         i2c_rxd_valid_o <= 1'b0;
         if (nack_clr_i) st_nack_o <= 1'b0;
         if ((state == IDLE) || (state == HOLD)) tmr <= RELOAD;
         else if (!stall) tmr <= (tmr == 10'd0) ? RELOAD : tmr - 10'd1;
         if (qend) q <= q + 2'd1;
         case (state)
            IDLE: begin
               scl_oe_o <= 1'b0;
               sda_oe_o <= 1'b0;
               if (i2c_txd_valid_i) begin
                  i2c_txd_ready_o <= 1'b1;
                  shift           <= i2c_txd_data_i[7:0];
                  dir             <= i2c_txd_data_i[8];
                  state           <= START;
               end
            end
            START:
               if (qend) begin
                  if (q == 2'd1) sda_oe_o <= 1'b1;
                  if (q == 2'd2) scl_oe_o <= 1'b1;
                  if (q == 2'd3) begin
                     state    <= BIT;
                     bitc     <= 3'd7;
                     sda_oe_o <= ~dir & ~shift[7];
                  end
               end
            BIT: begin
               if ((q == 2'd3) && first) shift <= {shift[6:0], sda_i};
               if (qend && (q == 2'd1)) scl_oe_o <= 1'b0;
               if (qend && (q == 2'd3)) begin
                  scl_oe_o <= 1'b1;
                  bitc     <= bitc - 3'd1;
                  if (bitc == 3'd0) begin
                     state    <= ACK;
                     sda_oe_o <= dir & i2c_txd_valid_i & i2c_txd_data_i[8];
                  end else sda_oe_o <= ~dir & ~shift[7];
               end
            end
            ACK: begin
               if ((q == 2'd3) && first) begin
                  nak <= ~dir & sda_i;
                  if (~dir & sda_i) st_nack_o <= 1'b1;
               end
               // strobe lands on the final cycle of q3
               if ((q == 2'd3) && (tmr == 10'd1) && dir) begin
                  i2c_rxd_valid_o <= 1'b1;
                  i2c_rxd_data_o  <= shift;
               end
               if (qend && (q == 2'd1)) scl_oe_o <= 1'b0;
               if (qend && (q == 2'd3)) begin
                  scl_oe_o <= 1'b1;
                  if (nak) begin
                     state    <= STOP;
                     sda_oe_o <= 1'b1;
                  end else if (i2c_txd_valid_i) begin
                     i2c_txd_ready_o <= 1'b1;
                     shift           <= i2c_txd_data_i[7:0];
                     dir             <= i2c_txd_data_i[8];
                     bitc            <= 3'd7;
                     state           <= BIT;
                     sda_oe_o        <= new_sda;
                  end else if (auto_stop_i) begin
                     state    <= STOP;
                     sda_oe_o <= 1'b1;
                  end else begin
                     state    <= HOLD;
                     sda_oe_o <= 1'b0;
                  end
               end
            end
            HOLD:
               if (i2c_txd_valid_i) begin
                  i2c_txd_ready_o <= 1'b1;
                  shift           <= i2c_txd_data_i[7:0];
                  dir             <= i2c_txd_data_i[8];
                  bitc            <= 3'd7;
                  state           <= BIT;
                  sda_oe_o        <= new_sda;
               end else if (auto_stop_i) begin
                  state    <= STOP;
                  sda_oe_o <= 1'b1;
               end
            STOP:
               if (qend) begin
                  if (q == 2'd0) scl_oe_o <= 1'b0;
                  if (q == 2'd1) sda_oe_o <= 1'b0;
                  if (q == 2'd3) state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_tqvp_dlmiles_i2c_engine.sv
// tb_tqvp_dlmiles_i2c_engine: FIFO and I2C slave models around the engine, checked with immediate assertions.
module tb_tqvp_dlmiles_i2c_engine;
   localparam int DIV = 4;
   typedef struct packed {logic rd; logic [7:0] d; logic ack;} plan_t;
   logic clk = 0, rst_i = 1;
   logic [8:0] txd_data = 0;
   logic txd_valid = 0, auto_stop = 1, nack_clr = 0;
   logic ready, rxd_valid, scl_oe, sda_oe, busy, nack;
   logic [7:0] rxd_data;
   logic s_sda_low = 0;
   int str_req = 0, str_used = 0;
   logic scl_i, sda_i;
   assign scl_i = !(scl_oe || (str_used < str_req));
   assign sda_i = !(sda_oe || s_sda_low);
   always #5 clk = ~clk;
   // slave clock stretch: each posedge seen with SCL released but held low costs one cycle
   always @(posedge clk) if (!scl_oe && (str_used < str_req)) str_used <= str_used + 1;

   tqvp_dlmiles_i2c_engine #(.CLK_DIV(DIV)) dut (
      .clk(clk), .rst_i(rst_i), .i2c_txd_data_i(txd_data), .i2c_txd_valid_i(txd_valid),
      .i2c_txd_ready_o(ready), .i2c_rxd_data_o(rxd_data), .i2c_rxd_valid_o(rxd_valid),
      .auto_stop_i(auto_stop), .nack_clr_i(nack_clr), .scl_i(scl_i), .sda_i(sda_i),
      .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .st_busy_o(busy), .st_nack_o(nack));

   logic [8:0] fifo[$];
   plan_t plans[$], cur;
   logic cur_ok = 0, need_pop = 1, defer, pscl = 1, psda = 1, stretch_en = 0, nack_seen = 0;
   int bitn = 0;
   logic [7:0] sh;
   logic [7:0] wr_log[$], rx_log[$];
   logic ack_log[$];
   int starts, stops, busy_cyc, ready_cnt, ready_bad = 0, hold_bad, checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic slave();
      if (pscl && scl_i && psda && !sda_i) begin
         starts++;
         bitn = 0;
         if (!cur_ok) need_pop = 1;
      end else if (pscl && scl_i && !psda && sda_i) begin
         stops++;
         s_sda_low = 0;
      end else if (!pscl && scl_i) begin
         if (bitn < 8) begin
            sh = {sh[6:0], sda_i};
            bitn++;
            if (bitn == 8 && cur_ok && !cur.rd) wr_log.push_back(sh);
         end else if (bitn == 8) begin
            ack_log.push_back(sda_i);
            bitn = 9;
         end
      end else if (pscl && !scl_i) begin
         defer = 0;
         if (bitn == 9) begin
            bitn = 0;
            need_pop = 1;
            defer = cur_ok && cur.rd && ack_log[$];
            cur_ok = 0;
         end
         if (need_pop && !defer && plans.size() != 0) begin
            cur = plans.pop_front();
            cur_ok = 1;
            need_pop = 0;
         end
         if (stretch_en && bitn == 4) begin
            str_req = str_used + 10;
            stretch_en = 0;
         end
         s_sda_low = cur_ok && ((bitn < 8) ? (cur.rd && !cur.d[3'(7 - bitn)]) : (bitn == 8 && !cur.rd && cur.ack));
      end
      pscl = scl_i;
      psda = sda_i;
   endtask

   task automatic step();
      @(negedge clk);
      if (ready) begin
         ready_cnt++;
         if (fifo.size() == 0 || !txd_valid) ready_bad++;
         else void'(fifo.pop_front());
      end
      if (busy) busy_cyc++;
      if (nack) nack_seen = 1;
      if (rxd_valid) rx_log.push_back(rxd_data);
      slave();
      txd_valid = fifo.size() != 0;
      txd_data = txd_valid ? fifo[0] : 9'd0;
   endtask

   task automatic push(input logic rd, input logic [7:0] d, input logic ack);
      plan_t p;
      p.rd = rd; p.d = d; p.ack = ack;
      plans.push_back(p);
      fifo.push_back({rd, rd ? 8'($urandom) : d});
      txd_valid = 1;
      txd_data = fifo[0];
   endtask

   task automatic clr();
      wr_log.delete(); rx_log.delete(); ack_log.delete();
      starts = 0; stops = 0; busy_cyc = 0; ready_cnt = 0;
   endtask

   task automatic run_until_idle(input string tag, input int lim);
      int n = 0;
      do begin step(); n++; end while ((busy || fifo.size() != 0) && n < lim);
      chk(tag, n < lim, 1);
   endtask

   initial begin
      logic [7:0] b, b1, d0, d1;
      int n, k;
      logic rd[3];
      logic [7:0] dd[3];
      logic [7:0] ew[$], er[$];
      logic ea[$];
      repeat (3) step();
      rst_i = 0;
      step();
      chk("reset_outputs", {scl_oe, sda_oe, ready, rxd_valid, rxd_data, busy, nack}, 0);

      for (int i = 0; i < 2; i++) begin
         b = (i == 0) ? 8'hA5 : 8'($urandom);
         clr();
         push(0, b, 1);
         run_until_idle("write_timeout", 1000);
         chk("write_byte", wr_log.size() == 1 ? wr_log[0] : 8'hxx, b);
         chk("write_ack", ack_log.size() == 1 ? ack_log[0] : 1'bx, 0);
         chk("write_busy_cycles", busy_cyc, 44 * DIV);
         chk("write_ready_count", ready_cnt, 1);
         chk("write_start_stop", {starts[7:0], stops[7:0]}, 16'h0101);
         chk("write_nack_flag", nack, 0);
      end

      clr();
      push(0, 8'h50, 0);
      push(0, 8'h33, 1);
      run_until_idle("nack_timeout", 2000);
      chk("nack_flag", nack, 1);
      chk("nack_bytes", wr_log.size() == 2 ? {wr_log[0], wr_log[1]} : 16'hxxxx, 16'h5033);
      chk("nack_acks", ack_log.size() == 2 ? {ack_log[0], ack_log[1]} : 2'bxx, 2'b10);
      chk("nack_start_stop", {starts[7:0], stops[7:0]}, 16'h0202);
      nack_clr = 1;
      step();
      nack_clr = 0;
      step();
      chk("nack_clear", nack, 0);
      clr();
      nack_clr = 1;
      nack_seen = 0;
      push(0, 8'($urandom), 0);
      run_until_idle("nack_prio_timeout", 1000);
      nack_clr = 0;
      chk("nack_set_priority", nack_seen, 1);
      chk("nack_held_clear", nack, 0);

      for (int i = 0; i < 2; i++) begin
         d0 = (i == 0) ? 8'h3C : 8'($urandom);
         d1 = (i == 0) ? 8'hC3 : 8'($urandom);
         clr();
         push(1, d0, 0);
         push(1, d1, 0);
         run_until_idle("read_timeout", 2000);
         chk("read_bytes", rx_log.size() == 2 ? {rx_log[0], rx_log[1]} : 16'hxxxx, {d0, d1});
         chk("read_acks", ack_log.size() == 2 ? {ack_log[0], ack_log[1]} : 2'bxx, 2'b01);
         chk("read_busy_cycles", busy_cyc, (8 + 72) * DIV);
         chk("read_stops", stops, 1);
      end

      b = 8'($urandom);
      clr();
      stretch_en = 1;
      push(0, b, 1);
      run_until_idle("stretch_timeout", 1000);
      chk("stretch_busy_cycles", busy_cyc, 44 * DIV + 10);
      chk("stretch_byte", wr_log.size() == 1 ? wr_log[0] : 8'hxx, b);

      b = 8'($urandom);
      b1 = 8'($urandom);
      auto_stop = 0;
      clr();
      push(0, b, 1);
      repeat (170) step();
      hold_bad = 0;
      repeat (100) begin
         step();
         if (!(scl_oe && !sda_oe && busy)) hold_bad++;
      end
      chk("hold_bus_levels", hold_bad, 0);
      chk("hold_no_stop", stops, 0);
      push(0, b1, 1);
      repeat (170) step();
      auto_stop = 1;
      run_until_idle("hold_timeout", 200);
      chk("hold_bytes", wr_log.size() == 2 ? {wr_log[0], wr_log[1]} : 16'hxxxx, {b, b1});
      chk("hold_start_stop", {starts[7:0], stops[7:0], ready_cnt[7:0]}, 24'h010102);

      clr();
      push(0, 8'($urandom), 1);
      n = 0;
      while (bitn < 4 && n < 2000) begin step(); n++; end
      chk("reset_reach_bit4", n < 2000, 1);
      #2 rst_i = 1;
      #1 chk("async_reset_outputs", {scl_oe, sda_oe, ready, rxd_valid, rxd_data, busy, nack}, 0);
      step();
      step();
      fifo.delete(); plans.delete();
      bitn = 0; cur_ok = 0; need_pop = 1; s_sda_low = 0;
      rst_i = 0;
      step();
      b = 8'($urandom);
      clr();
      push(0, b, 1);
      run_until_idle("post_reset_timeout", 1000);
      chk("post_reset_byte", wr_log.size() == 1 ? wr_log[0] : 8'hxx, b);
      chk("post_reset_busy", {starts[7:0], busy_cyc[15:0]}, {8'd1, 16'(44 * DIV)});

      for (int t = 0; t < 4; t++) begin
         n = $urandom_range(1, 3);
         clr();
         ew.delete(); er.delete(); ea.delete();
         for (int i = 0; i < n; i++) begin
            rd[i] = 1'($urandom);
            dd[i] = 8'($urandom);
            push(rd[i], dd[i], 1);
            if (rd[i]) er.push_back(dd[i]);
            else ew.push_back(dd[i]);
         end
         for (int i = 0; i < n; i++) ea.push_back(rd[i] ? !(i < n - 1 && rd[i + 1]) : 1'b0);
         run_until_idle("mix_timeout", 3000);
         chk("mix_busy_cycles", busy_cyc, (8 + 36 * n) * DIV);
         chk("mix_counts", {wr_log.size(), rx_log.size(), ack_log.size()}, {ew.size(), er.size(), ea.size()});
         k = 0;
         foreach (ew[i]) if (i < wr_log.size() && wr_log[i] !== ew[i]) k++;
         foreach (er[i]) if (i < rx_log.size() && rx_log[i] !== er[i]) k++;
         foreach (ea[i]) if (i < ack_log.size() && ack_log[i] !== ea[i]) k++;
         chk("mix_data_and_acks", k, 0);
         chk("mix_start_stop_ready", {starts[7:0], stops[7:0], ready_cnt[7:0]}, {8'd1, 8'd1, 8'(n)});
      end

      chk("ready_only_when_valid", ready_bad, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tqvp_dlmiles_i2c_engine.md
# tqvp_dlmiles_i2c_engine

I2C master bit/byte engine sitting directly downstream of the I2C FIFO. It consumes 9-bit `{dir,data}` entries from the FIFO's TX side, generates START, byte, ACK and STOP bus sequences on open-drain SCL/SDA, and pushes received bytes into the FIFO's RX side. It is single-master: clock stretching is honoured, and there is no arbitration.

## Interface
- `CLK_DIV`, default 160: `clk` cycles per quarter SCL bit (64 MHz / (4×160) = 100 kHz); legal values 2..1023.
- `clk` in 1: project clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `i2c_txd_data_i` in 9: bit 8 is dir (0 = TXD write byte, 1 = RXD read byte); bits 7:0 are the write data (ignored when dir = 1).
- `i2c_txd_valid_i` in 1: FIFO head entry valid.
- `i2c_txd_ready_o` out 1: one-cycle strobe that consumes the head entry.
- `i2c_rxd_data_o` out 8: received byte.
- `i2c_rxd_valid_o` out 1: one-cycle strobe that pushes `i2c_rxd_data_o`.
- `auto_stop_i` in 1: 1 = issue STOP when the FIFO is empty after a byte; 0 = hold the bus (SCL low) waiting for more entries.
- `nack_clr_i` in 1: clears `st_nack_o`.
- `scl_i`, `sda_i` in 1 each: synchronised bus levels.
- `scl_oe_o`, `sda_oe_o` out 1 each: 1 = drive low, 0 = release.
- `st_busy_o` out 1: state != IDLE.
- `st_nack_o` out 1: sticky flag, set when a written byte is NACKed.

## Operation
- **States:** IDLE, START, BIT, ACK, HOLD, STOP.
- **Quarter timer:** 10-bit down-counter reloaded with `CLK_DIV-1`; a quarter ends when it reaches 0. The 2-bit quarter index q advances at each quarter end. The 3-bit bit counter counts 7→0, MSB first.
- **IDLE:** both `oe` = 0. When `i2c_txd_valid_i`=1:
  - strobe ready, latch the entry into the shift register and dir flag;
  - go to START.
- **START:**
  - q0–q1: SDA released, SCL released.
  - q2: SDA low.
  - q3: SDA low, SCL low.
  - Then go to BIT with bit = 7.
- **BIT:**
  - q0–q1: SCL low. At the start of q0, SDA is set: TXD drives `~shift[7]`; RXD releases SDA.
  - q2: SCL released. The timer is frozen while `scl_i`=0 (clock stretch).
  - q3: SCL high. At the first q3 cycle, `sda_i` is shifted into the shift LSB.
  - After q3 of bit 0, go to ACK.
- **ACK** (same 4 quarters):
  - TXD: SDA released, `sda_i` sampled in q3; sample = 1 sets `st_nack_o`.
  - RXD: `sda_oe_o`=1 (ACK) if, at entry to ACK, `i2c_txd_valid_i`=1 and `i2c_txd_data_i[8]`=1; otherwise NACK (released).
  - RXD: in the last cycle of ACK q3, `i2c_rxd_valid_o`=1 with `i2c_rxd_data_o` = shift[7:0].
  - After ACK:
    - TXD was NACKed → STOP.
    - Else if `i2c_txd_valid_i` → strobe ready, latch, BIT with bit = 7.
    - Else if `auto_stop_i` → STOP.
    - Else → HOLD.
- **HOLD:** SCL low, SDA released.
  - `i2c_txd_valid_i` → strobe, latch, BIT.
  - `auto_stop_i` becomes 1 → STOP.
- **STOP:**
  - q0: SCL low, SDA low.
  - q1: SCL released, SDA low, with stretch wait.
  - q2–q3: both released.
  - Then go to IDLE.
- **NACK flag:** `st_nack_o` set has priority over `nack_clr_i` in the same cycle.
- Repeated START is not supported; a new transaction starts from IDLE.

## Timing
- **Reset** (async assert, sync release): state IDLE; all outputs 0 (`scl_oe_o`=`sda_oe_o`=0, strobes 0, `i2c_rxd_data_o`=0, `st_busy_o`=0, `st_nack_o`=0); timer = `CLK_DIV-1`.
- **Reset mid-transfer:** the bus is released immediately; no STOP is generated, and the FIFO entry already consumed is lost.
- **`i2c_txd_ready_o`:**
  - High exactly one cycle per consumed entry, and only while `i2c_txd_valid_i`=1.
  - The latch happens in the same cycle; the FIFO advances on the next edge.
- **Start-up latency:** IDLE valid → ready strobe is 1 cycle. START lasts 4×`CLK_DIV` cycles.
- **Byte cost:** each byte plus ACK is 36×`CLK_DIV` cycles when there is no stretch. Each stretched cycle adds exactly 1 cycle.
- **Back-to-back bytes:** no HOLD gap when the next entry is valid at the end of ACK.
- **Write/read dir change** mid-transaction is allowed without START: the following byte simply reads.
- **Received byte:** `i2c_rxd_valid_o` is a single-cycle strobe. FIFO overrun is reported by the FIFO, not here.

## Test plan
- **Write byte:** `CLK_DIV`=4, `auto_stop_i`=1; push 0x0A5 with a slave model that ACKs.
  - START, then SDA bits 1,0,1,0,0,1,0,1 at SCL rises, then ACK, then STOP.
  - One ready strobe; `st_nack_o`=0; `st_busy_o` high for 4+36+4 quarters = 176 cycles.
- **Write NACK:** slave NACKs 0x050 while a second entry 0x033 is pending.
  - `st_nack_o`=1, STOP follows, then a new START with 0x33.
  - `nack_clr_i` clears the flag.
- **Read two:** push 0x1xx, 0x1xx; slave returns 0x3C then 0xC3.
  - ACK after the first byte, NACK after the second.
  - Two `i2c_rxd_valid_o` strobes, data 0x3C then 0xC3, then STOP.
- **Clock stretch:** slave holds SCL low 10 cycles in bit 3.
  - Transfer lengthens by exactly 10 cycles; data intact.
- **HOLD:** `auto_stop_i`=0; one write, then an idle gap of 100 cycles.
  - SCL is held low and SDA released throughout the gap.
  - Setting `auto_stop_i` produces STOP, then IDLE.
- **Async reset mid-byte:** assert `rst_i` in bit 4.
  - All outputs are 0 in the same cycle.
  - After release, a new entry starts a clean START.
